mdu: RTL
========

# mdu

Multi-cycle multiply/divide unit for the pipelined MIPS core, one stage downstream of the general register file. It consumes both register-file read operands (rs, rt), runs `mult`/`multu`/`div`/`divu` over a fixed number of cycles, and holds the results in architectural HI/LO registers. It also services `mthi`/`mtlo`. `busy`, together with the issuing `start`, drives the hazard unit's stall of any following HI/LO instruction.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (>=1)
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (>=1)

Ports:
- clk  input  1  clock, all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- start  input  1  issue strobe for `op`, sampled on rising edge
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6/7 reserved
- A  input  32  operand from rs (GRF first read port)
- B  input  32  operand from rt (GRF second read port)
- busy  output  1  multi-cycle operation in flight
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- States: IDLE, BUSY. Down-counter plus pending result registers (hi_nxt, lo_nxt).
- IDLE + start + op 0–3: capture op/A/B; load counter; go to BUSY.
- Pending result may be computed at capture or iteratively, at implementer's choice. Only the commit timing is observable.
- IDLE + start + op 4 (mthi): HI <= A next edge. Op 5 (mtlo): LO <= A. State stays IDLE.
- start with op 6/7: ignored.
- BUSY: counter decrements each cycle. On the final cycle's edge: {HI,LO} <= pending result, busy <= 0, state <= IDLE.
- start while BUSY (any op, including mthi/mtlo): ignored. Upstream must stall.
- mult: {HI,LO} = signed(A) × signed(B), 64-bit. multu: unsigned.
- div: LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend. divu: unsigned.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.
- Divide by zero (B = 0, div or divu): still occupies DIV_CYCLES. HI/LO are left unchanged at commit.
- rst = 0 at any time: immediately, without waiting for an edge, HI = 0, LO = 0, busy = 0, state IDLE, counter 0, pending result discarded.

## Timing
- Start accepted at edge E0. `busy` = 1 from just after E0 through edge E0+N, where N = MULT_CYCLES or DIV_CYCLES.
- `busy` is high for exactly N clock cycles.
- HI/LO take the new value at edge E0+N, the same edge `busy` falls. A `mfhi` issued in the cycle after that edge sees the result.
- A new start is accepted in the cycle after `busy` falls. No idle bubble is required.
- mthi/mtlo: 1-cycle latency, `busy` never asserts.
- During the start cycle itself `busy` = 0. The hazard unit stalls on (start && op<=3) || busy.
- HI/LO are stable (hold previous values) for the whole BUSY period.

## Configuration
- `MDU_FAST_EN` defined: MULT_CYCLES and DIV_CYCLES are ignored. mult/multu/div/divu commit HI/LO at edge E0 (the edge start is sampled), and `busy` never asserts. The state machine degenerates to IDLE only. Divide-by-zero and overflow rules still apply.
- Undefined: the multi-cycle behaviour above.

## Test plan
- Reset: hold rst = 0, pulse clk, release -> HI = 0, LO = 0, busy = 0. Assert rst = 0 mid-BUSY, between edges -> outputs clear without a clock edge.
- mult A = 0xFFFF_FFFE (-2), B = 3 at E0 -> busy high 5 cycles; at E5 HI = 0xFFFF_FFFF, LO = 0xFFFF_FFFA. Then multu with the same operands -> HI = 0x0000_0002, LO = 0xFFFF_FFFA.
- div A = -7, B = 2 -> after 10 cycles LO = 0xFFFF_FFFD (-3), HI = 0xFFFF_FFFF (-1). divu A = 7, B = 2 -> LO = 3, HI = 1. div 0x8000_0000 / -1 -> LO = 0x8000_0000, HI = 0.
- Divide by zero: preload HI = 0x1234 via mthi, then div A = 5, B = 0 -> busy 10 cycles, HI still 0x1234, LO unchanged.
- Start during BUSY: mult in flight, assert start with mtlo A = 0xDEAD at cycle 2 -> ignored; LO = mult result at commit. mtlo issued the cycle after busy falls -> LO = 0xDEAD one edge later.
- Back-to-back: multu 2×3 then divu 9/4 issued the cycle after busy falls -> LO = 6 at the first commit, then LO = 2, HI = 1 at the second. With `MDU_FAST_EN`, each commits in 1 cycle and busy stays 0.

Source files
------------

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit holding the architectural HI/LO
// registers. mult/multu/div/divu compute their result at issue and park it
// in a pending register; a down-counter then commits it to HI/LO after
// MULT_CYCLES/DIV_CYCLES cycles. mthi/mtlo write directly with 1-cycle latency.
// Build option: define MDU_FAST_EN to commit arithmetic results at the issue
// edge with busy never asserting (the FSM then stays in IDLE).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accepting start; mthi/mtlo write immediately
// BUSY  | counter running; pending result commits at terminal count
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(NMAX + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0]   hi_nxt, lo_nxt;
  logic          wr_nxt;

  logic [31:0]   res_hi, res_lo, dvsr;
  logic          res_wr;
  logic          cap, hi_we, lo_we;
  logic [31:0]   hi_d, lo_d;

  // Arithmetic result for the operands currently on A/B; divide by zero
  // suppresses the write so HI/LO keep their old values at commit.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b1;
    dvsr   = (B == 32'd0) ? 32'd1 : B;
    case (op)
      3'd0: {res_hi, res_lo} = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
      3'd1: {res_hi, res_lo} = {32'd0, A} * {32'd0, B};
      3'd2: begin
        if (B == 32'd0) begin
          res_wr = 1'b0;
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = $signed(A) / $signed(dvsr);
          res_hi = $signed(A) % $signed(dvsr);
        end
      end
      3'd3: begin
        res_wr = (B != 32'd0);
        res_lo = A / dvsr;
        res_hi = A % dvsr;
      end
      default: res_wr = 1'b0;
    endcase
  end

  // Next-state, counter and HI/LO write-enable decode.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cap     = 1'b0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    hi_d    = HI;
    lo_d    = LO;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
`ifdef MDU_FAST_EN
              hi_we = res_wr;
              lo_we = res_wr;
              hi_d  = res_hi;
              lo_d  = res_lo;
`else
              state_d = BUSY;
              cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              cap     = 1'b1;
`endif
            end
            3'd4: begin
              hi_we = 1'b1;
              hi_d  = A;
            end
            3'd5: begin
              lo_we = 1'b1;
              lo_d  = A;
            end
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_d = IDLE;
          hi_we   = wr_nxt;
          lo_we   = wr_nxt;
          hi_d    = hi_nxt;
          lo_d    = lo_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Pending result capture and architectural HI/LO update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_nxt <= '0;
      lo_nxt <= '0;
      wr_nxt <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      if (cap) begin
        hi_nxt <= res_hi;
        lo_nxt <= res_lo;
        wr_nxt <= res_wr;
      end
      if (hi_we) HI <= hi_d;
      if (lo_we) LO <= lo_d;
    end
  end

  assign busy = (state == BUSY);

endmodule
